// File: rtl/rv32_mod_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mod_bus_arbiter
// Description : Two-requester arbiter sharing one memory bus between the
//               instruction-fetch port and the load/store port. Registered
//               grant FSM, fixed data priority or round-robin tie-breaking,
//               and an optional per-transaction timeout that reports a bus
//               error to the waiting requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mod_bus_arbiter #(
  parameter int DATA_PRIORITY = 1,  // 1: data wins ties; 0: round-robin
  parameter int TIMEOUT       = 0   // grant cycles before a forced error; 0 = off
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,
  // load/store port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_data_o,
  // shared memory bus
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_data;      // 1 when the data port was the last one served
  logic   w_last_data_nxt;
  logic   w_tmo;            // granted access has waited TIMEOUT cycles

  // Timeout counter exists only when the timeout is enabled; it restarts in
  // IDLE so every grant begins counting from zero.
  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int c_CNT_W = $clog2(TIMEOUT + 1);
      logic [c_CNT_W-1:0] r_tcnt;

      assign w_tmo = (r_state != ST_IDLE) && (r_tcnt == c_CNT_W'(TIMEOUT));

      // Count grant cycles that have not yet completed.
      always_ff @(posedge clk) begin
        if (reset || (r_state == ST_IDLE)) begin
          r_tcnt <= '0;
        end else if (!w_tmo) begin
          r_tcnt <= r_tcnt + c_CNT_W'(1);
        end
      end
    end else begin : g_no_tmo
      assign w_tmo = 1'b0;
    end
  endgenerate

  // Grant state and round-robin history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last_data <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_data <= w_last_data_nxt;
    end
  end

  // Next-state decode plus bus/response muxing driven from the current grant.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_data_nxt = r_last_data;
    mem_req         = 1'b0;
    mem_wr          = 1'b0;
    mem_be          = 4'h0;
    mem_addr        = 32'h0;
    mem_data_o      = 32'h0;
    instr_ack       = 1'b0;
    instr_err       = 1'b0;
    instr_data_o    = 32'h0;
    data_ack        = 1'b0;
    data_err        = 1'b0;
    data_data_o     = 32'h0;

    case (r_state)
      ST_IDLE: begin
        if (instr_req && data_req) begin
          // Tie: data wins outright, or the port not served last wins.
          w_state_nxt = ((DATA_PRIORITY != 0) || !r_last_data) ? ST_GNT_D : ST_GNT_I;
        end else if (data_req) begin
          w_state_nxt = ST_GNT_D;
        end else if (instr_req) begin
          w_state_nxt = ST_GNT_I;
        end
      end

      ST_GNT_I: begin
        mem_addr = instr_addr;
        mem_be   = 4'hF;
        if (!instr_req) begin
          // Requester abandoned the access: release the bus silently.
          w_state_nxt = ST_IDLE;
        end else begin
          mem_req      = !w_tmo;
          instr_data_o = mem_data_i;
          instr_err    = mem_err | w_tmo;
          instr_ack    = mem_ack & ~mem_err & ~w_tmo;
          if (mem_ack || mem_err || w_tmo) begin
            w_state_nxt     = ST_IDLE;
            w_last_data_nxt = 1'b0;
          end
        end
      end

      ST_GNT_D: begin
        mem_addr   = data_addr;
        mem_be     = data_be;
        mem_wr     = data_wr;
        mem_data_o = data_data_i;
        if (!data_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          mem_req     = !w_tmo;
          data_data_o = mem_data_i;
          data_err    = mem_err | w_tmo;
          data_ack    = mem_ack & ~mem_err & ~w_tmo;
          if (mem_ack || mem_err || w_tmo) begin
            w_state_nxt     = ST_IDLE;
            w_last_data_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_mod_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_mod_bus_arbiter
// Description : Bench for rv32_mod_bus_arbiter. Two environments: data
//               priority with TIMEOUT=4, and round-robin without timeout.
//               Random requesters push expected responses into queues; a
//               monitor pops and compares, and tracks the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_mod_bus_arbiter;

  localparam int c_NTX   = 30;
  localparam int c_BOUND = 200;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Memory behaviour by address: 0 ack, 1 err, 2 ack+err together, 3 silent.
  function automatic int mem_kind(input logic [31:0] a);
    if (a[31:28] == 4'hE) return 3;
    if (a[3:2] == 2'b11)  return a[4] ? 2 : 1;
    return 0;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Expected requester response: {err, data}.
  function automatic logic [32:0] exp_resp(input logic [31:0] a);
    if (mem_kind(a) == 0) return {1'b0, mem_word(a)};
    return {1'b1, 32'h0};
  endfunction

  function automatic logic [31:0] gen_addr(input bit allow_silent);
    logic [31:0] a;
    a = $urandom();
    a[1:0] = 2'b00;
    if (a[31:28] == 4'hE) a[31:28] = 4'h2;
    if (allow_silent && ($urandom_range(9, 0) == 0)) a[31:28] = 4'hE;
    return a;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int DP  = (g == 0) ? 1 : 0;
    localparam int TMO = (g == 0) ? 4 : 0;

    logic        instr_req, instr_ack, instr_err;
    logic [31:0] instr_addr, instr_data_o;
    logic        data_req, data_wr, data_ack, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_data_i, data_data_o;
    logic        mem_req, mem_wr, mem_ack, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_data_o, mem_data_i;
    logic        rst_tst;
    logic        rst_env;
    logic [32:0] q_i[$];
    logic [32:0] q_d[$];
    bit          rnd_i, rnd_d, done_i, done_d;

    assign rst_env = reset | rst_tst;

    rv32_mod_bus_arbiter #(.DATA_PRIORITY(DP), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .reset(rst_env),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
      .instr_err(instr_err), .instr_data_o(instr_data_o),
      .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
      .data_addr(data_addr), .data_data_i(data_data_i), .data_ack(data_ack),
      .data_err(data_err), .data_data_o(data_data_o),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_data_o(mem_data_o), .mem_ack(mem_ack), .mem_err(mem_err),
      .mem_data_i(mem_data_i)
    );

    // Fetch requester: random addresses and gaps, then a fetch of 0x100.
    initial begin : p_instr
      int gap, k;
      instr_req = 1'b0; instr_addr = 32'h0; rnd_i = 0; done_i = 0;
      wait (reset === 1'b0);
      for (int n = 0; n < c_NTX; n++) begin
        gap = $urandom_range(3, 0);
        repeat (gap) begin @(posedge clk); #1; instr_req = 1'b0; end
        @(posedge clk); #1;
        instr_addr = gen_addr(TMO > 0);
        instr_req  = 1'b1;
        q_i.push_back(exp_resp(instr_addr));
        k = 0;
        do begin @(negedge clk); k++; end
        while (!(instr_ack === 1'b1 || instr_err === 1'b1) && k < c_BOUND);
        chk("i_wait_bound", (k < c_BOUND), 1);
      end
      @(posedge clk); #1; instr_req = 1'b0;
      rnd_i = 1;
      for (int w = 0; w < 5000 && !done_d; w++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      instr_addr = 32'h100;
      instr_req  = 1'b1;
      q_i.push_back(exp_resp(32'h100));
      k = 0;
      do begin @(negedge clk); k++; end
      while (!(instr_ack === 1'b1 || instr_err === 1'b1) && k < c_BOUND);
      chk("i_fetch100_bound", (k < c_BOUND), 1);
      @(posedge clk); #1; instr_req = 1'b0;
      done_i = 1;
    end

    // Load/store requester: random traffic, then a reset during a grant.
    initial begin : p_data
      int gap, k;
      data_req = 1'b0; data_wr = 1'b0; data_be = 4'h0; data_addr = 32'h0;
      data_data_i = 32'h0; rst_tst = 1'b0; rnd_d = 0; done_d = 0;
      wait (reset === 1'b0);
      for (int n = 0; n < c_NTX; n++) begin
        gap = $urandom_range(3, 0);
        repeat (gap) begin @(posedge clk); #1; data_req = 1'b0; end
        @(posedge clk); #1;
        data_addr   = gen_addr(TMO > 0);
        data_wr     = 1'($urandom_range(1, 0));
        data_be     = 4'($urandom_range(15, 1));
        data_data_i = $urandom();
        data_req    = 1'b1;
        q_d.push_back(exp_resp(data_addr));
        k = 0;
        do begin @(negedge clk); k++; end
        while (!(data_ack === 1'b1 || data_err === 1'b1) && k < c_BOUND);
        chk("d_wait_bound", (k < c_BOUND), 1);
      end
      @(posedge clk); #1; data_req = 1'b0;
      rnd_d = 1;
      for (int w = 0; w < 5000 && !rnd_i; w++) @(posedge clk);
      if (TMO > 0) begin
        repeat (8) @(posedge clk);
        #1;
        data_addr = 32'hE000_2000; data_wr = 1'b1; data_be = 4'h3;
        data_data_i = 32'hDEAD_BEEF; data_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst_tst = 1'b1; data_req = 1'b0;
        @(posedge clk); #1; rst_tst = 1'b0;
        repeat (6) @(posedge clk);
      end
      done_d = 1;
    end

    // Memory: ack/err after 1..3 cycles by address class; silent addresses
    // get a late ack 5 cycles after the grant.
    initial begin : p_mem
      bit          mactive, mwait;
      int          mcnt, mlat, kind;
      logic [31:0] maddr;
      mem_ack = 1'b0; mem_err = 1'b0; mem_data_i = 32'h0;
      mactive = 0; mwait = 0; mcnt = 0; mlat = 0; kind = 0; maddr = 32'h0;
      forever begin
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_err = 1'b0; mem_data_i = 32'h0;
        if (mactive) begin
          if (mcnt == mlat) begin
            mem_ack    = (kind != 1);
            mem_err    = (kind == 1) || (kind == 2);
            mem_data_i = mem_word(maddr);
            mactive    = 0;
            mwait      = 1;
          end else begin
            mcnt++;
          end
        end
        @(negedge clk);
        if (reset === 1'b1 || mem_req !== 1'b1) begin
          mwait = 0;
        end else if (!mactive && !mwait) begin
          mactive = 1;
          mcnt    = 1;
          maddr   = mem_addr;
          kind    = mem_kind(mem_addr);
          mlat    = (kind == 3) ? 5 : $urandom_range(3, 1);
        end
      end
    end

    // Monitor: response scoreboard plus arbitration-rule tracking.
    initial begin : p_mon
      bit          busy, port, last, tmo, pa, pe;
      int          gcnt;
      logic [32:0] e;
      busy = 0; port = 0; last = 0; gcnt = 0;
      forever begin
        @(negedge clk);
        if (rst_env === 1'b1) begin
          busy = 0; last = 0; gcnt = 0;
        end else begin
          if (instr_ack === 1'b1 || instr_err === 1'b1) begin
            if (q_i.size() == 0) chk("i_unexpected_resp", 1, 0);
            else begin
              e = q_i.pop_front();
              chk("i_resp_err", instr_err, e[32]);
              if (!e[32]) chk("i_resp_data", instr_data_o, e[31:0]);
            end
          end
          if (data_ack === 1'b1 || data_err === 1'b1) begin
            if (q_d.size() == 0) chk("d_unexpected_resp", 1, 0);
            else begin
              e = q_d.pop_front();
              chk("d_resp_err", data_err, e[32]);
              if (!e[32]) chk("d_resp_data", data_data_o, e[31:0]);
            end
          end

          if (!busy) begin
            chk("idle_req_ack_err", {mem_req, instr_ack, instr_err, data_ack, data_err}, 0);
            chk("idle_instr_data", instr_data_o, 0);
            chk("idle_data_data", data_data_o, 0);
            if (instr_req || data_req) begin
              busy = 1;
              gcnt = 0;
              if (instr_req && data_req) port = (DP != 0) ? 1'b1 : !last;
              else port = data_req;
            end
          end else begin
            tmo = (TMO > 0) && (gcnt == TMO);
            chk("gnt_mem_req", mem_req, !tmo);
            if (!tmo) begin
              if (port) begin
                chk("gnt_d_addr", mem_addr, data_addr);
                chk("gnt_d_wr", mem_wr, data_wr);
                chk("gnt_d_be", mem_be, data_be);
                chk("gnt_d_wdata", mem_data_o, data_data_i);
              end else begin
                chk("gnt_i_addr", mem_addr, instr_addr);
                chk("gnt_i_wr", mem_wr, 0);
                chk("gnt_i_be", mem_be, 4'hF);
                chk("gnt_i_wdata", mem_data_o, 0);
              end
            end
            pa = !tmo && mem_ack && !mem_err;
            pe = tmo || mem_err;
            chk("gnt_ack_err_vec", {instr_ack, instr_err, data_ack, data_err},
                port ? {2'b00, pa, pe} : {pa, pe, 2'b00});
            if (port) chk("gnt_i_data_quiet", instr_data_o, 0);
            else      chk("gnt_d_data_quiet", data_data_o, 0);
            if (pa) chk("gnt_ack_data", port ? data_data_o : instr_data_o, mem_data_i);
            if (tmo || mem_ack || mem_err) begin
              busy = 0;
              last = port;
            end else begin
              gcnt++;
            end
          end
        end
      end
    end
  end

  initial begin : p_main
    bit all_done;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    all_done = 0;
    for (int c = 0; c < 30000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_env[0].done_i && g_env[0].done_d && g_env[1].done_i && g_env[1].done_d;
    end
    chk("all_envs_done", all_done, 1);
    repeat (4) @(posedge clk);
    chk("env0_i_queue_empty", g_env[0].q_i.size(), 0);
    chk("env0_d_queue_empty", g_env[0].q_d.size(), 0);
    chk("env1_i_queue_empty", g_env[1].q_i.size(), 0);
    chk("env1_d_queue_empty", g_env[1].q_d.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
